tv_checker: RTL and testbench

- Response-side counterpart to our exhaustive-stimulus benches: a synthesizable checker that samples each applied input vector together with the DUT's observed output.
- Compares each observation against a parameterized truth table and confirms every input combination arrives exactly once, in ascending order.
- Counts mismatches and raises pass/done, so self-checking runs on hardware or in simulation without reading waveforms by eye.

---
 rtl/tv_checker_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/tv_checker.sv | 108 ++++++++++
 tb/tb_tv_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tv_checker_pkg.sv
// Shared definitions for the truth-table response checker: FSM encoding and
// default truth tables of the combinational modules it is used against.
package tv_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] EXPECT_SILLY = 8'b0011_0001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/tv_checker.sv
// Response checker: compares each accepted (in_vec, y_obs) sample against a
// truth table and verifies the vectors arrive once each, in ascending order.
module tv_checker
  import tv_checker_pkg::*;
#(
  parameter int unsigned           N_IN   = 3,
  parameter logic [2**N_IN-1:0]    EXPECT = EXPECT_SILLY,
  parameter int unsigned           ERR_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             y_obs,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] seq_err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int unsigned     IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'((1 << N_IN) - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [N_IN-1:0]  r_first_err_vec;
  logic             r_first_err_valid;

  logic w_accept;
  logic w_start_run;
  logic w_mismatch;
  logic w_seq_bad;

  assign w_accept    = (r_state == RUN) && s_valid;
  // Start is honoured from IDLE and DONE alike; in RUN it is ignored.
  assign w_start_run = start && (r_state != RUN);
  assign w_mismatch  = (y_obs != EXPECT[in_vec]);
  assign w_seq_bad   = ({1'b0, in_vec} != r_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_accept && (r_idx == LAST)) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx             <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (w_start_run) begin
      r_idx             <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (w_accept) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_mismatch && !r_first_err_valid) begin
        r_first_err_vec   <= in_vec;
        r_first_err_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_run),
    .inc   (w_accept && w_mismatch),
    .q     (err_count)
  );

  sat_counter #(.W(ERR_W)) u_seq_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_run),
    .inc   (w_accept && w_seq_bad),
    .q     (seq_err_count)
  );

  // Outputs decode only registered state, so pass sees the final sample's counts.
  always_comb begin
    busy            = (r_state == RUN);
    s_ready         = (r_state == RUN);
    done            = (r_state == DONE);
    pass            = (r_state == DONE) && (err_count == '0) && (seq_err_count == '0);
    first_err_vec   = r_first_err_vec;
    first_err_valid = r_first_err_valid;
  end

endmodule

// File: tb/tb_tv_checker.sv
// Bench for tv_checker: two instances (ERR_W=4 and ERR_W=2) share stimulus and
// are compared every cycle against a queue-based model of the accepted samples.
module tb_tv_checker;

  localparam int         NV  = 8;
  localparam logic [7:0] EXP = 8'b0011_0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic       y_obs = 1'b0;
  logic [2:0] in_vec = 3'd0;

  logic       a_s_ready, a_busy, a_done, a_pass, a_fev_valid;
  logic [3:0] a_err, a_seq;
  logic [2:0] a_fev;
  logic       b_s_ready, b_busy, b_done, b_pass, b_fev_valid;
  logic [1:0] b_err, b_seq;
  logic [2:0] b_fev;

  tv_checker #(.N_IN(3), .EXPECT(EXP), .ERR_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec), .y_obs(y_obs),
    .s_valid(s_valid), .s_ready(a_s_ready), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .seq_err_count(a_seq),
    .first_err_vec(a_fev), .first_err_valid(a_fev_valid)
  );

  tv_checker #(.N_IN(3), .EXPECT(EXP), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec), .y_obs(y_obs),
    .s_valid(s_valid), .s_ready(b_s_ready), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .seq_err_count(b_seq),
    .first_err_vec(b_fev), .first_err_valid(b_fev_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: a run is just the list of samples accepted since the last start.
  bit         m_started = 1'b0;
  logic [2:0] m_vec[$];
  bit         m_mis[$];

  function automatic bit exp_y(input logic [2:0] v);
    return bit'((EXP >> v) & 8'd1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b0;
      m_vec.delete();
      m_mis.delete();
    end else if (m_started && m_vec.size() < NV) begin
      if (s_valid) begin
        m_vec.push_back(in_vec);
        m_mis.push_back(y_obs != exp_y(in_vec));
      end
    end else if (start) begin
      m_started = 1'b1;
      m_vec.delete();
      m_mis.delete();
    end
  end

  function automatic int m_err();
    int n = 0;
    foreach (m_mis[i]) if (m_mis[i]) n++;
    return n;
  endfunction

  function automatic int m_seq();
    int n = 0;
    foreach (m_vec[i]) if (int'(m_vec[i]) != i) n++;
    return n;
  endfunction

  function automatic int m_fev();
    foreach (m_mis[i]) if (m_mis[i]) return int'(m_vec[i]);
    return 0;
  endfunction

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit run, fin, ok;
      run = m_started && (m_vec.size() < NV);
      fin = m_started && (m_vec.size() == NV);
      ok  = fin && (m_err() == 0) && (m_seq() == 0);
      chk("a_busy", 32'(a_busy), 32'(run));
      chk("a_s_ready", 32'(a_s_ready), 32'(run));
      chk("a_done", 32'(a_done), 32'(fin));
      chk("a_pass", 32'(a_pass), 32'(ok));
      chk("a_err", 32'(a_err), 32'(sat(m_err(), 4)));
      chk("a_seq", 32'(a_seq), 32'(sat(m_seq(), 4)));
      chk("a_fev", 32'(a_fev), 32'(m_fev()));
      chk("a_fev_valid", 32'(a_fev_valid), 32'(m_err() != 0));
      chk("b_done", 32'(b_done), 32'(fin));
      chk("b_pass", 32'(b_pass), 32'(ok));
      chk("b_err", 32'(b_err), 32'(sat(m_err(), 2)));
      chk("b_seq", 32'(b_seq), 32'(sat(m_seq(), 2)));
      chk("b_fev", 32'(b_fev), 32'(m_fev()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; s_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic start_run(input bit with_valid);
    start = 1'b1; s_valid = with_valid;
    in_vec = 3'($urandom_range(7, 0)); y_obs = 1'($urandom);
    cyc();
    start = 1'b0; s_valid = 1'b0;
  endtask

  // Idle cycles carry random junk on the data lines and optional start pulses.
  task automatic idle(input int n, input bit noise_valid, input bit noise_start);
    for (int i = 0; i < n; i++) begin
      s_valid = noise_valid ? 1'($urandom) : 1'b0;
      start   = noise_start ? 1'($urandom) : 1'b0;
      in_vec  = 3'($urandom_range(7, 0));
      y_obs   = 1'($urandom);
      cyc();
    end
    s_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send(input logic [2:0] v, input bit y, input int gap, input bit rnd_start);
    idle(gap, 1'b0, rnd_start);
    s_valid = 1'b1; in_vec = v; y_obs = y;
    start = rnd_start ? 1'($urandom) : 1'b0;
    cyc();
    s_valid = 1'b0; start = 1'b0;
  endtask

  task automatic full_run(input logic [7:0] inv, input int gap, input bit swap23, input bit sv);
    logic [2:0] v;
    start_run(sv);
    for (int i = 0; i < NV; i++) begin
      v = 3'(i);
      if (swap23 && i == 2) v = 3'd3;
      if (swap23 && i == 3) v = 3'd2;
      send(v, exp_y(v) ^ inv[v], (gap < 0) ? $urandom_range(3, 0) : gap, 1'b0);
    end
  endtask

  task automatic lit_a(input string tag, input int dn, input int ps, input int er,
                       input int sq, input int fv, input int fvv);
    chk({tag, "_done"}, 32'(a_done), 32'(dn));
    chk({tag, "_pass"}, 32'(a_pass), 32'(ps));
    chk({tag, "_err"}, 32'(a_err), 32'(er));
    chk({tag, "_seq"}, 32'(a_seq), 32'(sq));
    chk({tag, "_fev"}, 32'(a_fev), 32'(fv));
    chk({tag, "_fevv"}, 32'(a_fev_valid), 32'(fvv));
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_s_ready), 32'd0);
    lit_a("rst", 0, 0, 0, 0, 0, 0);

    idle(4, 1'b1, 1'b0);
    chk("idle_noise_busy", 32'(a_busy), 32'd0);
    lit_a("idle_noise", 0, 0, 0, 0, 0, 0);

    full_run(8'h00, 0, 1'b0, 1'b0);
    lit_a("clean", 1, 1, 0, 0, 0, 0);

    idle(4, 1'b1, 1'b0);
    lit_a("done_noise", 1, 1, 0, 0, 0, 0);

    full_run(8'b0010_0100, 0, 1'b0, 1'b1);
    lit_a("inv25", 1, 0, 2, 0, 2, 1);

    full_run(8'h00, 0, 1'b1, 1'b0);
    lit_a("swap", 1, 0, 0, 2, 0, 0);

    full_run(8'h00, 2, 1'b0, 1'b0);
    lit_a("gap3", 1, 1, 0, 0, 0, 0);

    start_run(1'b0);
    for (int i = 0; i < 4; i++) send(3'(i), exp_y(3'(i)), 0, 1'b0);
    chk("mid_busy", 32'(a_busy), 32'd1);
    do_reset();
    chk("midrst_busy", 32'(a_busy), 32'd0);
    lit_a("midrst", 0, 0, 0, 0, 0, 0);
    full_run(8'h00, 1, 1'b0, 1'b0);
    lit_a("after_rst", 1, 1, 0, 0, 0, 0);

    full_run(8'hFF, 0, 1'b0, 1'b0);
    chk("sat_b_err", 32'(b_err), 32'd3);
    chk("sat_b_pass", 32'(b_pass), 32'd0);
    lit_a("allinv", 1, 0, 8, 0, 0, 1);
    full_run(8'h00, 0, 1'b0, 1'b1);
    chk("resat_b_err", 32'(b_err), 32'd0);
    chk("resat_b_pass", 32'(b_pass), 32'd1);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(5, 0) == 0) do_reset();
      idle($urandom_range(3, 0), 1'b1, 1'b0);
      start_run(1'($urandom));
      for (int i = 0; i < NV; i++) begin
        logic [2:0] v;
        v = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'(i);
        send(v, ($urandom_range(4, 0) == 0) ? ~exp_y(v) : exp_y(v),
             $urandom_range(2, 0), 1'b1);
      end
      idle($urandom_range(3, 0), 1'b1, 1'b0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
